// File: rtl/sdram_init_seq_if.sv
// Control handshake between the system-level sequencer and sdram_init_seq.
interface sdram_init_seq_if;
  logic ireq;
  logic ienb;
  logic ofin;
  logic obusy;

  modport master (output ireq, output ienb, input ofin, input obusy);
  modport slave  (input ireq, input ienb, output ofin, output obusy);
endinterface

// File: rtl/sdram_init_seq.sv
// SDRAM power-up initialisation sequencer: NOP wait, PALL, NUM_REF x REF, MRS, then hands the bus over via ofin.
// Optional periodic auto-refresh while idle in DONE: define SDRAM_INIT_AUTO_REF_EN.
module sdram_init_seq #(
  parameter int ADDR_W       = 13,
  parameter int BA_W         = 2,
  parameter int DQ_W         = 16,
  parameter int T_POWERUP    = 16,
  parameter int T_RP         = 2,
  parameter int T_RFC        = 7,
  parameter int T_MRD        = 2,
  parameter int NUM_REF      = 8,
  parameter int CAS_LAT      = 2,
  parameter int BURST_LEN    = 3,
  parameter int BURST_TYPE   = 0,
  parameter int WB_SINGLE    = 1,
  parameter int REF_INTERVAL = 390
) (
  input  logic              iclk,
  input  logic              ireset_n,
  sdram_init_seq_if.slave   ctrl,
  output wire               DRAM_CLK,
  output wire               DRAM_CKE,
  output wire [ADDR_W-1:0]  DRAM_ADDR,
  output wire [BA_W-1:0]    DRAM_BA,
  output wire               DRAM_CS_N,
  output wire               DRAM_RAS_N,
  output wire               DRAM_CAS_N,
  output wire               DRAM_WE_N,
  output wire               DRAM_LDQM,
  output wire               DRAM_UDQM,
  inout  wire [DQ_W-1:0]    DRAM_DQ
);

  localparam logic [3:0] CMD_NOP  = 4'b0111;
  localparam logic [3:0] CMD_PALL = 4'b0010;
  localparam logic [3:0] CMD_REF  = 4'b0001;
  localparam logic [3:0] CMD_MRS  = 4'b0000;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // One wait counter serves every timed state, including the refresh interval in DONE.
  localparam int MAX_T  = max2(max2(T_POWERUP, REF_INTERVAL), max2(T_RFC, max2(T_RP, T_MRD)));
  localparam int WAIT_W = $clog2(MAX_T + 1);
  localparam int REF_W  = $clog2(NUM_REF + 1);

  localparam logic [WAIT_W-1:0] LAST_PU   = WAIT_W'(T_POWERUP - 1);
  localparam logic [WAIT_W-1:0] LAST_RP   = WAIT_W'(T_RP - 2);
  localparam logic [WAIT_W-1:0] LAST_RFC  = WAIT_W'(T_RFC - 2);
  localparam logic [WAIT_W-1:0] LAST_MRD  = WAIT_W'(T_MRD - 2);
  localparam logic [REF_W-1:0]  REF_TOTAL = REF_W'(NUM_REF);
`ifdef SDRAM_INIT_AUTO_REF_EN
  localparam logic [WAIT_W-1:0] LAST_IVAL = WAIT_W'(REF_INTERVAL - 1);
`endif

  localparam logic [2:0] CAS_F  = 3'(CAS_LAT);
  localparam logic [2:0] BL_F   = 3'(BURST_LEN);
  localparam logic       BT_F   = 1'(BURST_TYPE);
  localparam logic       WB_F   = 1'(WB_SINGLE);

  function automatic logic [ADDR_W-1:0] mode_word();
    logic [ADDR_W-1:0] m;
    m      = '0;
    m[9]   = WB_F;
    m[6:4] = CAS_F;
    m[3]   = BT_F;
    m[2:0] = BL_F;
    return m;
  endfunction

  localparam logic [ADDR_W-1:0] MODE_WORD = mode_word();

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_POWERUP   = 4'd1,
    S_PRECHARGE = 4'd2,
    S_WAIT_RP   = 4'd3,
    S_REFRESH   = 4'd4,
    S_WAIT_RFC  = 4'd5,
    S_LOAD_MODE = 4'd6,
    S_WAIT_MRD  = 4'd7,
    S_DONE      = 4'd8,
    S_AREF      = 4'd9,
    S_AREF_WAIT = 4'd10
  } state_e;

  state_e              state_q, state_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic [REF_W-1:0]    ref_q, ref_d;
  logic [3:0]          cmd_q, cmd_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [BA_W-1:0]     ba_q, ba_d;
  logic [1:0]          dqm_q, dqm_d;
  logic                cke_q, cke_d;
  logic                ofin_q, ofin_d;
  logic                obusy_q, obusy_d;
  logic                ienb_s;

  assign ienb_s = ctrl.ienb;

  // Next-state and counter logic; a released bus freezes progress (DONE keeps its interval timer running).
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    ref_d   = ref_q;
    if (ienb_s || (state_q == S_DONE)) begin
      case (state_q)
        S_IDLE: begin
          if (ctrl.ireq) begin
            state_d = S_POWERUP;
            wait_d  = '0;
            ref_d   = '0;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_POWERUP: begin
          if (wait_q == LAST_PU) begin
            state_d = S_PRECHARGE;
            wait_d  = '0;
          end else begin
            wait_d = wait_q + WAIT_W'(1);
          end
        end
        S_PRECHARGE: begin
          state_d = S_WAIT_RP;
          wait_d  = '0;
        end
        S_WAIT_RP: begin
          if (wait_q == LAST_RP) begin
            state_d = S_REFRESH;
            wait_d  = '0;
          end else begin
            wait_d = wait_q + WAIT_W'(1);
          end
        end
        S_REFRESH: begin
          state_d = S_WAIT_RFC;
          wait_d  = '0;
          ref_d   = ref_q + REF_W'(1);
        end
        S_WAIT_RFC: begin
          if (wait_q == LAST_RFC) begin
            state_d = (ref_q < REF_TOTAL) ? S_REFRESH : S_LOAD_MODE;
            wait_d  = '0;
          end else begin
            wait_d = wait_q + WAIT_W'(1);
          end
        end
        S_LOAD_MODE: begin
          state_d = S_WAIT_MRD;
          wait_d  = '0;
        end
        S_WAIT_MRD: begin
          if (wait_q == LAST_MRD) begin
            state_d = S_DONE;
            wait_d  = '0;
          end else begin
            wait_d = wait_q + WAIT_W'(1);
          end
        end
`ifdef SDRAM_INIT_AUTO_REF_EN
        // Entering AREF even with the bus released lets the REF go out on the first owned cycle.
        S_DONE: begin
          if (wait_q == LAST_IVAL) begin
            state_d = S_AREF;
            wait_d  = '0;
          end else begin
            wait_d = wait_q + WAIT_W'(1);
          end
        end
        S_AREF: begin
          state_d = S_AREF_WAIT;
          wait_d  = '0;
        end
        S_AREF_WAIT: begin
          if (wait_q == LAST_RFC) begin
            state_d = S_DONE;
            wait_d  = '0;
          end else begin
            wait_d = wait_q + WAIT_W'(1);
          end
        end
`else
        S_DONE: begin
          state_d = S_DONE;
        end
`endif
        default: begin
          state_d = S_IDLE;
          wait_d  = '0;
          ref_d   = '0;
        end
      endcase
    end else begin
      state_d = state_q;
      wait_d  = wait_q;
      ref_d   = ref_q;
    end
  end

  // Pin values are decoded from the next state so each registered pin matches the state it is issued in.
  always_comb begin
    cmd_d  = CMD_NOP;
    addr_d = '0;
    ba_d   = '0;
    dqm_d  = 2'b11;
    cke_d  = 1'b1;
    case (state_d)
      S_IDLE:      cke_d = 1'b0;
      S_PRECHARGE: begin
        cmd_d      = CMD_PALL;
        addr_d[10] = 1'b1;
        ba_d       = {BA_W{1'b1}};
      end
      S_REFRESH:   cmd_d = CMD_REF;
      S_LOAD_MODE: begin
        cmd_d  = CMD_MRS;
        addr_d = MODE_WORD;
      end
      S_DONE:      dqm_d = 2'b00;
      S_AREF: begin
        cmd_d = CMD_REF;
        dqm_d = 2'b00;
      end
      S_AREF_WAIT: dqm_d = 2'b00;
      default:     cmd_d = CMD_NOP;
    endcase
    ofin_d  = (state_d == S_DONE);
    obusy_d = (state_d != S_IDLE) && (state_d != S_DONE);
  end

  // State, counters and all pin/status registers.
  always_ff @(posedge iclk or negedge ireset_n) begin
    if (!ireset_n) begin
      state_q <= S_IDLE;
      wait_q  <= '0;
      ref_q   <= '0;
      cmd_q   <= CMD_NOP;
      addr_q  <= '0;
      ba_q    <= '0;
      dqm_q   <= 2'b11;
      cke_q   <= 1'b0;
      ofin_q  <= 1'b0;
      obusy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      ref_q   <= ref_d;
      cmd_q   <= cmd_d;
      addr_q  <= addr_d;
      ba_q    <= ba_d;
      dqm_q   <= dqm_d;
      cke_q   <= cke_d;
      ofin_q  <= ofin_d;
      obusy_q <= obusy_d;
    end
  end

  assign ctrl.ofin  = ofin_q;
  assign ctrl.obusy = obusy_q;

  assign DRAM_CLK   = ienb_s ? ~iclk    : 1'bz;
  assign DRAM_CKE   = ienb_s ? cke_q    : 1'bz;
  assign DRAM_ADDR  = ienb_s ? addr_q   : {ADDR_W{1'bz}};
  assign DRAM_BA    = ienb_s ? ba_q     : {BA_W{1'bz}};
  assign DRAM_CS_N  = ienb_s ? cmd_q[3] : 1'bz;
  assign DRAM_RAS_N = ienb_s ? cmd_q[2] : 1'bz;
  assign DRAM_CAS_N = ienb_s ? cmd_q[1] : 1'bz;
  assign DRAM_WE_N  = ienb_s ? cmd_q[0] : 1'bz;
  assign DRAM_UDQM  = ienb_s ? dqm_q[1] : 1'bz;
  assign DRAM_LDQM  = ienb_s ? dqm_q[0] : 1'bz;
  assign DRAM_DQ    = {DQ_W{1'bz}};

endmodule

// File: tb/tb_sdram_init_seq.sv
// Bench for sdram_init_seq: a default instance and a retimed instance checked every cycle against a schedule model.
module tb_sdram_init_seq;
  localparam int TP   = 16;
  localparam int TMRD = 2;
  localparam int RI   = 20;

  logic clk, rst_n, ireq, ienb;
  int   n_cmp, n_err;

  sdram_init_seq_if if_a ();
  sdram_init_seq_if if_b ();
  assign if_a.ireq = ireq;
  assign if_a.ienb = ienb;
  assign if_b.ireq = ireq;
  assign if_b.ienb = ienb;

  wire        dclk_a, cke_a, cs_a, ras_a, cas_a, we_a, ldqm_a, udqm_a;
  wire [12:0] addr_a;
  wire [1:0]  ba_a;
  wire [15:0] dq_a;
  wire        dclk_b, cke_b, cs_b, ras_b, cas_b, we_b, ldqm_b, udqm_b;
  wire [12:0] addr_b;
  wire [1:0]  ba_b;
  wire [15:0] dq_b;

  sdram_init_seq #(.REF_INTERVAL(RI)) dut_a (
    .iclk(clk), .ireset_n(rst_n), .ctrl(if_a),
    .DRAM_CLK(dclk_a), .DRAM_CKE(cke_a), .DRAM_ADDR(addr_a), .DRAM_BA(ba_a),
    .DRAM_CS_N(cs_a), .DRAM_RAS_N(ras_a), .DRAM_CAS_N(cas_a), .DRAM_WE_N(we_a),
    .DRAM_LDQM(ldqm_a), .DRAM_UDQM(udqm_a), .DRAM_DQ(dq_a));

  sdram_init_seq #(.T_RP(3), .T_RFC(9), .NUM_REF(2), .CAS_LAT(3), .REF_INTERVAL(RI)) dut_b (
    .iclk(clk), .ireset_n(rst_n), .ctrl(if_b),
    .DRAM_CLK(dclk_b), .DRAM_CKE(cke_b), .DRAM_ADDR(addr_b), .DRAM_BA(ba_b),
    .DRAM_CS_N(cs_b), .DRAM_RAS_N(ras_b), .DRAM_CAS_N(cas_b), .DRAM_WE_N(we_b),
    .DRAM_LDQM(ldqm_b), .DRAM_UDQM(udqm_b), .DRAM_DQ(dq_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: progress index p counts owned cycles since the first POWERUP cycle.
  bit st[2];
  int p[2], aref_p[2], dcnt[2], rise[2];
  bit prev_fin[2];
  int cyc;

  function automatic int trp(input int k);  return (k == 0) ? 2 : 3; endfunction
  function automatic int trfc(input int k); return (k == 0) ? 7 : 9; endfunction
  function automatic int nref(input int k); return (k == 0) ? 8 : 2; endfunction
  function automatic int cas(input int k);  return (k == 0) ? 2 : 3; endfunction
  function automatic int ref0(input int k); return TP + trp(k); endfunction
  function automatic int mrs_at(input int k); return ref0(k) + nref(k) * trfc(k); endfunction
  function automatic int done_at(input int k); return mrs_at(k) + TMRD; endfunction
  // WB_SINGLE=1 at bit 9, CAS at bits 6:4, sequential burst, BL8 code 3.
  function automatic int mode(input int k); return 1 * 512 + cas(k) * 16 + 0 * 8 + 3; endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      st[k] = 1'b0; p[k] = 0; aref_p[k] = -1; dcnt[k] = 0; prev_fin[k] = 1'b0;
    end
  endtask

  task automatic model_step();
    if (!rst_n) begin
      model_reset();
    end else begin
      if (!st[0] && ireq && ienb) begin
        cyc = 0; rise[0] = -1; rise[1] = -1;
      end else begin
        cyc++;
      end
      for (int k = 0; k < 2; k++) begin
        if (!st[k]) begin
          if (ireq && ienb) begin
            st[k] = 1'b1; p[k] = 0; aref_p[k] = -1; dcnt[k] = 0;
          end
        end else if (p[k] < done_at(k)) begin
          if (ienb) p[k]++;
        end else begin
`ifdef SDRAM_INIT_AUTO_REF_EN
          if (aref_p[k] < 0) begin
            if (dcnt[k] == RI - 1) begin aref_p[k] = 0; dcnt[k] = 0; end
            else dcnt[k]++;
          end else if (ienb) begin
            aref_p[k]++;
            if (aref_p[k] == trfc(k)) aref_p[k] = -1;
          end
`endif
        end
      end
    end
  endtask

  task automatic check_one(input int k, input logic [3:0] cmd, input logic cke, input logic [1:0] dqm,
                           input logic [12:0] addr, input logic [1:0] ba, input logic fin, input logic busy);
    string n;
    logic [3:0] e_cmd;
    logic e_cke, e_fin, e_busy;
    logic [1:0] e_dqm;
    bit idle, chk_dqm;
    n = (k == 0) ? "a" : "b";
    idle = 1'b0; chk_dqm = 1'b1; e_cke = 1'b1; e_dqm = 2'b11; e_cmd = 4'b0111;
    if (!st[k]) begin
      idle = 1'b1; e_cke = 1'b0; e_fin = 1'b0; e_busy = 1'b0;
    end else if (p[k] < done_at(k)) begin
      e_fin = 1'b0; e_busy = 1'b1;
      if (p[k] == TP) e_cmd = 4'b0010;
      else if (p[k] >= ref0(k) && p[k] < mrs_at(k) && ((p[k] - ref0(k)) % trfc(k)) == 0) e_cmd = 4'b0001;
      else if (p[k] == mrs_at(k)) e_cmd = 4'b0000;
      else e_cmd = 4'b0111;
    end else if (aref_p[k] >= 0) begin
      e_fin = 1'b0; e_busy = 1'b1; chk_dqm = 1'b0;
      e_cmd = (aref_p[k] == 0) ? 4'b0001 : 4'b0111;
    end else begin
      e_fin = 1'b1; e_busy = 1'b0; e_dqm = 2'b00;
    end
    chk({n, ".ofin"}, fin, e_fin);
    chk({n, ".obusy"}, busy, e_busy);
    if (fin && !prev_fin[k] && rise[k] < 0) rise[k] = cyc;
    prev_fin[k] = fin;
    if (ienb) begin
      chk({n, ".cmd"}, cmd, e_cmd);
      chk({n, ".cke"}, cke, e_cke);
      if (chk_dqm) chk({n, ".dqm"}, dqm, e_dqm);
      if (idle) begin
        chk({n, ".idle_addr"}, addr, 0);
        chk({n, ".idle_ba"}, ba, 0);
      end
      if (e_cmd == 4'b0010) begin
        chk({n, ".pall_a10"}, addr[10], 1);
        chk({n, ".pall_ba"}, ba, 3);
      end
      if (st[k] && p[k] == mrs_at(k)) begin
        chk({n, ".mrs_addr"}, addr, mode(k));
        chk({n, ".mrs_ba"}, ba, 0);
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
    check_one(0, {cs_a, ras_a, cas_a, we_a}, cke_a, {udqm_a, ldqm_a}, addr_a, ba_a, if_a.ofin, if_a.obusy);
    check_one(1, {cs_b, ras_b, cas_b, we_b}, cke_b, {udqm_b, ldqm_b}, addr_b, ba_b, if_b.ofin, if_b.obusy);
    if (ienb) chk("a.dram_clk", dclk_a, 1);
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic start();
    ienb = 1'b1; ireq = 1'b1;
    tick();
    ireq = 1'b0;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0; model_reset();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    n_cmp = 0; n_err = 0; cyc = 0; rise[0] = -1; rise[1] = -1;
    rst_n = 1'b0; ireq = 1'b0; ienb = 1'b1;
    model_reset();
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (20) tick();

    // Uninterrupted run: ofin rises at 76 (defaults) and 39 (retimed).
    start();
    repeat (150) tick();
    chk("a.ofin_cycle", rise[0], 76);
    chk("b.ofin_cycle", rise[1], 39);

    // Bus released for cycles 30..39: everything shifts by 10.
    pulse_reset();
    start();
    repeat (100) begin
      tick();
      ienb = (cyc >= 30 && cyc < 40) ? 1'b0 : 1'b1;
    end
    ienb = 1'b1;
    chk("a.ofin_shifted", rise[0], 86);
    chk("b.ofin_shifted", rise[1], 49);

    // Reset at cycle 40 aborts; a fresh request replays the whole sequence.
    pulse_reset();
    start();
    repeat (40) tick();
    rst_n = 1'b0; model_reset();
    #1;
    chk("rst.ofin", if_a.ofin, 0);
    chk("rst.obusy", if_a.obusy, 0);
    chk("rst.cke", cke_a, 0);
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    start();
    repeat (90) tick();
    chk("a.ofin_restart", rise[0], 76);

    // Random bus ownership and spurious requests.
    for (int r = 0; r < 4; r++) begin
      pulse_reset();
      repeat (300) begin
        ireq = ($urandom_range(0, 9) == 0);
        ienb = ($urandom_range(0, 3) != 0);
        tick();
      end
    end
    ienb = 1'b1; ireq = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
